// File: rtl/spin_sweep_scheduler_if.sv
// Handshake bundle between the core control/tree side and the spin sweep scheduler.
// The master drives the run controls and tree sum. The slave (the scheduler) drives the row issue and status.
interface spin_sweep_scheduler_if #(
  parameter int NUM_SPINS = 32,
  parameter int SUM_SIZE  = 12,
  parameter int ITER_W    = 16
);
  localparam int IDX_W = $clog2(NUM_SPINS);

  logic                 start;
  logic                 abort;
  logic [ITER_W-1:0]    num_sweeps;
  logic                 stop_on_stable;
  logic [NUM_SPINS-1:0] spin_init;
  logic [SUM_SIZE-1:0]  sum_in;

  logic                 row_valid;
  logic [IDX_W-1:0]     row_idx;
  logic                 current_spin;
  logic [NUM_SPINS-1:0] spins_out;
  logic                 busy;
  logic                 done;
  logic [ITER_W-1:0]    sweep_count;
  logic [IDX_W:0]       flips_last;

  modport master (
    output start, abort, num_sweeps, stop_on_stable, spin_init, sum_in,
    input  row_valid, row_idx, current_spin, spins_out, busy, done,
           sweep_count, flips_last
  );

  modport slave (
    input  start, abort, num_sweeps, stop_on_stable, spin_init, sum_in,
    output row_valid, row_idx, current_spin, spins_out, busy, done,
           sweep_count, flips_last
  );
endinterface

// File: rtl/spin_sweep_scheduler.sv
// Ising sweep sequencer: issues one row per spin to the reduce-adder tree and flips spins whose local sum is negative.
// It repeats sweeps until the programmed count is reached or a sweep produces no flips.
module spin_sweep_scheduler #(
  parameter int NUM_SPINS     = 32,
  parameter int SUM_SIZE      = 12,
  parameter int ADDER_LATENCY = 2,
  parameter int PIPELINED     = 0,
  parameter int ITER_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spin_sweep_scheduler_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_SPINS);
  localparam int CNT_W = IDX_W + 1;
  localparam int TW    = (ADDER_LATENCY > 0) ? ADDER_LATENCY : 1;
  localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(NUM_SPINS - 1);
  localparam logic [ITER_W-1:0] SWEEP_MAX = '1;
  localparam logic [TW-1:0]     LAST_MASK = TW'(1) << (TW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_EVAL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_SPINS-1:0] r_spins;
  logic [NUM_SPINS-1:0] r_shadow;
  logic [IDX_W-1:0]     r_rowIdx;
  logic [TW-1:0]        r_tagValid;
  logic [IDX_W-1:0]     r_tagIdx [TW];
  logic [ITER_W-1:0]    r_numSweeps;
  logic                 r_stopOnStable;
  logic [ITER_W-1:0]    r_sweepCount;
  logic [CNT_W-1:0]     r_flipCnt;
  logic [CNT_W-1:0]     r_flipsLast;

  logic                 w_rowValid;
  logic                 w_pipeEmpty;
  logic                 w_drainDone;
  logic                 w_resValid;
  logic [IDX_W-1:0]     w_resIdx;
  logic                 w_flip;
  logic [ITER_W-1:0]    w_sweepNext;
  logic                 w_finish;

  // The tag at the end of the delay line marks the row whose sum is on sum_in this cycle.
  generate
    if (ADDER_LATENCY == 0) begin : g_comb_tree
      assign w_resValid  = w_rowValid;
      assign w_resIdx    = r_rowIdx;
      assign w_pipeEmpty = 1'b1;
      assign w_drainDone = 1'b1;
    end else begin : g_pipe_tree
      assign w_resValid  = r_tagValid[TW-1];
      assign w_resIdx    = r_tagIdx[TW-1];
      assign w_pipeEmpty = ~|r_tagValid;
      assign w_drainDone = ~|(r_tagValid & ~LAST_MASK);
    end
  endgenerate

  assign w_rowValid  = (r_state == S_ISSUE) && ((PIPELINED != 0) || w_pipeEmpty);
  assign w_flip      = w_resValid && bus.sum_in[SUM_SIZE-1];
  assign w_sweepNext = (r_sweepCount == SWEEP_MAX) ? r_sweepCount
                                                   : r_sweepCount + ITER_W'(1);
  assign w_finish    = (w_sweepNext == r_numSweeps) ||
                       (r_stopOnStable && (r_flipCnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = (bus.num_sweeps == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_rowValid && (r_rowIdx == LAST_ROW)) begin
          w_next = (ADDER_LATENCY == 0) ? S_EVAL : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drainDone) begin
          w_next = S_EVAL;
        end
      end
      S_EVAL: begin
        w_next = w_finish ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (bus.abort) begin
      w_next = S_IDLE;
    end
  end

  // Abort drops in-flight tags and the uncommitted shadow, but keeps the committed spins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spins        <= '0;
      r_shadow       <= '0;
      r_rowIdx       <= '0;
      r_tagValid     <= '0;
      for (int i = 0; i < TW; i++) begin
        r_tagIdx[i] <= '0;
      end
      r_numSweeps    <= '0;
      r_stopOnStable <= 1'b0;
      r_sweepCount   <= '0;
      r_flipCnt      <= '0;
      r_flipsLast    <= '0;
    end else begin
      for (int i = TW - 1; i > 0; i--) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagIdx[i]   <= r_tagIdx[i-1];
      end
      r_tagValid[0] <= w_rowValid;
      r_tagIdx[0]   <= r_rowIdx;

      if (bus.abort) begin
        r_tagValid <= '0;
        r_shadow   <= r_spins;
        r_rowIdx   <= '0;
        r_flipCnt  <= '0;
      end else if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_spins        <= bus.spin_init;
          r_shadow       <= bus.spin_init;
          r_numSweeps    <= bus.num_sweeps;
          r_stopOnStable <= bus.stop_on_stable;
          r_sweepCount   <= '0;
          r_flipsLast    <= '0;
          r_flipCnt      <= '0;
          r_rowIdx       <= '0;
        end
      end else begin
        if (w_rowValid) begin
          r_rowIdx <= (r_rowIdx == LAST_ROW) ? '0 : r_rowIdx + IDX_W'(1);
        end
        // Serial mode writes straight through so later rows see earlier flips.
        if (w_flip) begin
          r_flipCnt <= r_flipCnt + CNT_W'(1);
          if (PIPELINED != 0) begin
            r_shadow[w_resIdx] <= ~r_shadow[w_resIdx];
          end else begin
            r_spins[w_resIdx] <= ~r_spins[w_resIdx];
          end
        end
        if (r_state == S_EVAL) begin
          if (PIPELINED != 0) begin
            r_spins <= r_shadow;
          end
          r_flipsLast  <= r_flipCnt;
          r_sweepCount <= w_sweepNext;
          r_flipCnt    <= '0;
        end
      end
    end
  end

  assign bus.row_valid    = w_rowValid;
  assign bus.row_idx      = r_rowIdx;
  assign bus.current_spin = w_rowValid & r_spins[r_rowIdx];
  assign bus.spins_out    = r_spins;
  assign bus.busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN) ||
                            (r_state == S_EVAL);
  assign bus.done         = (r_state == S_DONE);
  assign bus.sweep_count  = r_sweepCount;
  assign bus.flips_last   = r_flipsLast;

endmodule

// File: tb/tb_spin_sweep_scheduler.sv
// Directed bench for spin_sweep_scheduler: a serial and a pipelined instance (4 spins, 2-cycle tree) are driven from a vector table.
// A small tree model returns a per-row field, sign-flipped when the issued spin is 1.
module tb_spin_sweep_scheduler;

  localparam int N   = 4;
  localparam int SW  = 12;
  localparam int IW  = 16;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spin_sweep_scheduler_if #(.NUM_SPINS(N), .SUM_SIZE(SW), .ITER_W(IW)) ifS ();
  spin_sweep_scheduler_if #(.NUM_SPINS(N), .SUM_SIZE(SW), .ITER_W(IW)) ifP ();

  spin_sweep_scheduler #(
    .NUM_SPINS(N), .SUM_SIZE(SW), .ADDER_LATENCY(LAT), .PIPELINED(0), .ITER_W(IW)
  ) dutS (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifS.slave)
  );

  spin_sweep_scheduler #(
    .NUM_SPINS(N), .SUM_SIZE(SW), .ADDER_LATENCY(LAT), .PIPELINED(1), .ITER_W(IW)
  ) dutP (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifP.slave)
  );

  // Tree model: remembers what was issued two edges ago and returns that row's field.
  logic signed [SW-1:0] hTab [N];
  logic [1:0] dIdxS [2];
  logic [1:0] dIdxP [2];
  logic       dSpS [2];
  logic       dSpP [2];

  always @(posedge clk) begin
    dIdxS[1] <= dIdxS[0];
    dIdxS[0] <= ifS.row_idx;
    dSpS[1]  <= dSpS[0];
    dSpS[0]  <= ifS.current_spin;
    dIdxP[1] <= dIdxP[0];
    dIdxP[0] <= ifP.row_idx;
    dSpP[1]  <= dSpP[0];
    dSpP[0]  <= ifP.current_spin;
  end

  assign ifS.sum_in = dSpS[1] ? SW'(-hTab[dIdxS[1]]) : hTab[dIdxS[1]];
  assign ifP.sum_in = dSpP[1] ? SW'(-hTab[dIdxP[1]]) : hTab[dIdxP[1]];

  logic          curPipe;
  logic          selRowValid;
  logic [1:0]    selRowIdx;
  logic [N-1:0]  selSpins;
  logic          selBusy;
  logic          selDone;
  logic [IW-1:0] selSweeps;
  logic [2:0]    selFlips;

  assign selRowValid = curPipe ? ifP.row_valid   : ifS.row_valid;
  assign selRowIdx   = curPipe ? ifP.row_idx     : ifS.row_idx;
  assign selSpins    = curPipe ? ifP.spins_out   : ifS.spins_out;
  assign selBusy     = curPipe ? ifP.busy        : ifS.busy;
  assign selDone     = curPipe ? ifP.done        : ifS.done;
  assign selSweeps   = curPipe ? ifP.sweep_count : ifS.sweep_count;
  assign selFlips    = curPipe ? ifP.flips_last  : ifS.flips_last;

  typedef struct {
    logic          pipe;
    logic [N-1:0]  spinInit;
    int            h0, h1, h2, h3;
    logic [IW-1:0] numSweeps;
    logic          stopOnStable;
    logic [N-1:0]  expSpins;
    int            expFlips;
    int            expSweeps;
    int            expDone;
    int            expRows;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic vec_t mkVec(input logic pipe, input logic [N-1:0] init,
                                 input int h0, input int h1, input int h2, input int h3,
                                 input int num, input logic stop, input logic [N-1:0] eSp,
                                 input int eFl, input int eSw, input int eDn, input int eRw);
    vec_t v;
    v.pipe = pipe;  v.spinInit = init;
    v.h0 = h0;  v.h1 = h1;  v.h2 = h2;  v.h3 = h3;
    v.numSweeps = IW'(num);  v.stopOnStable = stop;
    v.expSpins = eSp;  v.expFlips = eFl;  v.expSweeps = eSw;
    v.expDone = eDn;  v.expRows = eRw;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic setInputs(input logic pipe, input logic st, input logic ab,
                           input logic [N-1:0] init, input logic [IW-1:0] num,
                           input logic stop);
    if (pipe) begin
      ifP.start = st;  ifP.abort = ab;  ifP.spin_init = init;
      ifP.num_sweeps = num;  ifP.stop_on_stable = stop;
    end else begin
      ifS.start = st;  ifS.abort = ab;  ifS.spin_init = init;
      ifS.num_sweeps = num;  ifS.stop_on_stable = stop;
    end
  endtask

  task automatic setField(input int h0, input int h1, input int h2, input int h3);
    hTab[0] = SW'(h0);  hTab[1] = SW'(h1);  hTab[2] = SW'(h2);  hTab[3] = SW'(h3);
  endtask

  // Start pulse is sampled at edge 0; cycle c is the interval after edge c-1.
  task automatic applyStimulus(input vec_t v, output int doneCyc, output int rows,
                               output int busyFirst, output int busyAtDone);
    curPipe = v.pipe;
    setField(v.h0, v.h1, v.h2, v.h3);
    @(negedge clk);
    setInputs(v.pipe, 1'b1, 1'b0, v.spinInit, v.numSweeps, v.stopOnStable);
    @(posedge clk);
    #1 setInputs(v.pipe, 1'b0, 1'b0, v.spinInit, v.numSweeps, v.stopOnStable);
    doneCyc = -1;  rows = 0;  busyFirst = -1;  busyAtDone = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) busyFirst = int'(selBusy);
      if (selRowValid) rows++;
      if (selDone) begin
        doneCyc = c;
        busyAtDone = int'(selBusy);
        break;
      end
    end
  endtask

  vec_t vecs [8];

  initial begin
    int doneCyc, rows, busyFirst, busyAtDone, doneSeen;

    vecs[0] = mkVec(0, 4'b0000, -3, -3, -3, -3,  1, 0, 4'b1111, 4, 1, 14,  4);
    vecs[1] = mkVec(1, 4'b0000,  5,  5,  5,  5, 10, 1, 4'b0000, 0, 1,  8,  4);
    vecs[2] = mkVec(0, 4'b1010,  0,  0,  0,  0,  1, 0, 4'b1010, 0, 1, 14,  4);
    vecs[3] = mkVec(0, 4'b1001, -3, -3, -3, -3,  0, 0, 4'b1001, 0, 0,  1,  0);
    vecs[4] = mkVec(1, 4'b0000, -1,  2,  0, -7,  3, 0, 4'b1001, 0, 3, 22, 12);
    vecs[5] = mkVec(0, 4'b0000, -1,  2,  0, -7,  5, 1, 4'b1001, 0, 2, 27,  8);
    vecs[6] = mkVec(1, 4'b1111,  4,  4,  4,  4,  1, 0, 4'b0000, 4, 1,  8,  4);
    vecs[7] = mkVec(0, 4'b0110,  1,  1, -1, -1,  1, 0, 4'b1100, 2, 1, 14,  4);

    curPipe = 1'b0;
    setField(0, 0, 0, 0);
    setInputs(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    setInputs(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("resetSerial", {ifS.row_valid, ifS.row_idx, ifS.current_spin, ifS.spins_out,
                ifS.busy, ifS.done, ifS.sweep_count, ifS.flips_last}, '0);
    checkOutput("resetPipe", {ifP.row_valid, ifP.row_idx, ifP.current_spin, ifP.spins_out,
                ifP.busy, ifP.done, ifP.sweep_count, ifP.flips_last}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], doneCyc, rows, busyFirst, busyAtDone);
      checkOutput($sformatf("v%0d.doneCycle", i), doneCyc, vecs[i].expDone);
      checkOutput($sformatf("v%0d.rows", i), rows, vecs[i].expRows);
      checkOutput($sformatf("v%0d.busyCycle1", i), busyFirst, (vecs[i].numSweeps != 0) ? 1 : 0);
      checkOutput($sformatf("v%0d.busyAtDone", i), busyAtDone, 0);
      checkOutput($sformatf("v%0d.spins", i), selSpins, vecs[i].expSpins);
      checkOutput($sformatf("v%0d.flipsLast", i), selFlips, vecs[i].expFlips);
      checkOutput($sformatf("v%0d.sweepCount", i), selSweeps, vecs[i].expSweeps);
      @(negedge clk);
      checkOutput($sformatf("v%0d.donePulse", i), selDone, 0);
    end

    // Abort during the third issue of sweep 2 on the pipelined instance.
    curPipe = 1'b1;
    setField(-1, 2, 0, -7);
    @(negedge clk);
    setInputs(1'b1, 1'b1, 1'b0, 4'b0000, 16'd5, 1'b0);
    @(posedge clk);
    #1 setInputs(1'b1, 1'b0, 1'b0, 4'b0000, 16'd5, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 8) begin
        checkOutput("abort.sweep1Spins", selSpins, 4'b1001);
        setField(3, 3, 3, 3);
      end
      if (c == 10) begin
        checkOutput("abort.thirdIssue", {selRowValid, selRowIdx}, {1'b1, 2'd2});
        ifP.abort = 1'b1;
      end
    end
    @(posedge clk);
    #1 ifP.abort = 1'b0;
    @(negedge clk);
    checkOutput("abort.busyNext", selBusy, 0);
    checkOutput("abort.spinsKept", selSpins, 4'b1001);
    doneSeen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (selDone || selRowValid) doneSeen++;
    end
    checkOutput("abort.noDoneNoIssue", doneSeen, 0);
    applyStimulus(mkVec(1, 4'b0000, -3, -3, -3, -3, 1, 0, 4'b1111, 4, 1, 8, 4),
                  doneCyc, rows, busyFirst, busyAtDone);
    checkOutput("abort.restartDone", doneCyc, 8);
    checkOutput("abort.restartSpins", selSpins, 4'b1111);
    checkOutput("abort.restartFlips", selFlips, 4);

    // Start and abort together in IDLE: abort wins.
    @(negedge clk);
    setInputs(1'b1, 1'b1, 1'b1, 4'b0101, 16'd1, 1'b0);
    @(posedge clk);
    #1 setInputs(1'b1, 1'b0, 1'b0, 4'b0101, 16'd1, 1'b0);
    @(negedge clk);
    checkOutput("startAbort.idle", {selBusy, selDone, selRowValid}, 3'b000);
    checkOutput("startAbort.spinsKept", selSpins, 4'b1111);

    // Serial run: a start while busy is ignored, then an async reset lands mid-DRAIN.
    curPipe = 1'b0;
    setField(-3, -3, -3, -3);
    @(negedge clk);
    setInputs(1'b0, 1'b1, 1'b0, 4'b0000, 16'd1, 1'b0);
    @(posedge clk);
    #1 setInputs(1'b0, 1'b0, 1'b0, 4'b0000, 16'd1, 1'b0);
    doneSeen = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (selDone) doneSeen++;
      if (c == 5) setInputs(1'b0, 1'b1, 1'b0, 4'b0101, 16'd0, 1'b0);
      if (c == 6) setInputs(1'b0, 1'b0, 1'b0, 4'b0101, 16'd0, 1'b0);
    end
    checkOutput("busyStart.noDone", doneSeen, 0);
    checkOutput("busyStart.midDrain", {selBusy, selRowValid, selSpins}, {1'b1, 1'b0, 4'b0111});
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset.outputs", {ifS.row_valid, ifS.row_idx, ifS.current_spin, ifS.spins_out,
                ifS.busy, ifS.done, ifS.sweep_count, ifS.flips_last}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("asyncReset.idle", {selBusy, selDone, selSpins}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spin_sweep_scheduler.md
# spin_sweep_scheduler

Sequences Ising spin-update sweeps through the pipelined reduce-adder tree. The block issues one row index per spin, together with that spin's value, as the tree's `current_spin`. It captures the signed local-field sum returned by the tree and decides whether to flip the spin. Sweeps repeat until a programmed count is reached, or until a sweep produces no flips. The block sits between the core control register file and the row-weight fetch / reduce-adder datapath.

## Interface
- `NUM_SPINS`, 32 — spins per sweep; ≥2.
- `SUM_SIZE`, 12 — width of the tree sum.
- `ADDER_LATENCY`, 2 — clock edges from `row_valid` to a valid `sum_in`; 0 means combinational, same cycle.
- `PIPELINED`, 0 — 0: serial update, one row in flight; 1: issue one row per cycle, with updates committed at sweep end.
- `ITER_W`, 16 — width of the sweep counter.
- `clk` in 1 — clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — sampled only in IDLE; starts a run.
- `abort` in 1 — returns the block to IDLE from any state.
- `num_sweeps` in ITER_W — sweep limit, sampled with `start`.
- `stop_on_stable` in 1 — end the run after a zero-flip sweep; sampled with `start`.
- `spin_init` in NUM_SPINS — initial spins (1 = spin +1), sampled with `start`.
- `sum_in` in SUM_SIZE — 2's-complement tree output, already multiplied by −1 when the issued spin bit = 1.
- `row_valid` out 1 — a row is issued this cycle.
- `row_idx` out $clog2(NUM_SPINS) — index of the issued row.
- `current_spin` out 1 — `spins_out[row_idx]` at issue, driven to the tree.
- `spins_out` out NUM_SPINS — committed spin state; it also drives the external weight×spin product.
- `busy` out 1 — run in progress.
- `done` out 1 — one-cycle pulse at run end.
- `sweep_count` out ITER_W — number of completed sweeps.
- `flips_last` out $clog2(NUM_SPINS)+1 — flips counted in the last completed sweep.

## Operation
- **States:** IDLE, ISSUE, DRAIN, EVAL, DONE.
- **IDLE, `start`=1:**
  - Load `spins_out`←`spin_init`; clear counters; latch `num_sweeps` and `stop_on_stable`.
  - Go to ISSUE, or to DONE if `num_sweeps`=0. No rows are issued in the zero case.
- **ISSUE:**
  - Issues rows 0..NUM_SPINS−1 in order.
  - A tag shift register, ADDER_LATENCY deep, carries index and valid to match each returned sum.
- **Flip rule:** flip spin i iff the returned `sum_in` has MSB=1 (strictly negative). A zero sum means no flip.
- **PIPELINED=0:**
  - The next row is issued only after the previous result is written to `spins_out`.
  - Later rows therefore see earlier updates (Gauss-Seidel order).
- **PIPELINED=1:**
  - Rows are issued back-to-back.
  - Flips go to a shadow register; `spins_out` stays constant during the sweep, so every row sees the same state.
  - The shadow register is copied to `spins_out` in EVAL.
- **DRAIN:** after the last issue, wait for outstanding results. Skipped when ADDER_LATENCY=0 and PIPELINED=0.
- **EVAL (1 cycle):**
  - Commit (PIPELINED=1); `flips_last`←sweep flip count; `sweep_count`+1.
  - Go to DONE if the new `sweep_count`=`num_sweeps`, or if `stop_on_stable` and flips=0. Otherwise return to ISSUE at row 0.
- **DONE (1 cycle):** `done`=1, then IDLE.
- **`abort`:**
  - Has priority over every transition and forces IDLE on the next edge.
  - In-flight tags are cleared and results discarded.
  - The PIPELINED=1 shadow is discarded; `spins_out` keeps its committed value.
  - No `done` pulse is produced.
- **IDLE, `start` and `abort` both high:** abort wins.
- **`start` while not IDLE:** ignored.
- **`sum_in`:** ignored unless the tag valid bit is set.
- **`sweep_count`:** saturates at 2^ITER_W−1.

## Timing
- **Reset values:**
  - `row_valid`, `row_idx`, `current_spin`, `busy`, `done`, `spins_out`, `sweep_count`, `flips_last` = 0.
  - State = IDLE; tags cleared.
- **`busy`:** `start` sampled at edge 0 ⇒ `busy`=1 from cycle 1 through EVAL; `busy`=0 in the DONE cycle.
- **First issue:** `row_valid` first high in cycle 1 (row 0).
- **PIPELINED=0:**
  - Row k issues at cycle 1+k·(L+1), where L=ADDER_LATENCY.
  - Its result is sampled at 1+k·(L+1)+L and committed at the following edge.
- **PIPELINED=1:**
  - Row k issues at cycle 1+k; the last result is sampled at NUM_SPINS+L.
  - EVAL is the next cycle.
- **`done`:** pulses exactly one cycle after the final EVAL.

## Test plan
- **Serial, all flips:** NUM_SPINS=4, L=2, PIPELINED=0, `num_sweeps`=1, `spin_init`=4'b0000, `sum_in`=−3 for every row ⇒ rows issue at cycles 1, 4, 7, 10; `spins_out`=4'b1111; `flips_last`=4; `done` at cycle 14.
- **Pipelined, stable stop:** PIPELINED=1, NUM_SPINS=4, L=2, `stop_on_stable`=1, `num_sweeps`=10, `sum_in`=+5 always ⇒ `row_valid` high cycles 1–4; `spins_out` unchanged; `flips_last`=0; `sweep_count`=1; `done` at cycle 8.
- **Zero-sum boundary:** `sum_in`=0 with `current_spin` 0 and with 1 ⇒ no flip in either case.
- **Mid-run abort:** `abort` during the third issue of sweep 2, PIPELINED=1 ⇒ `spins_out` equals the end-of-sweep-1 value; `busy`=0 next cycle; no `done`; a following `start` works normally.
- **Zero sweeps:** `num_sweeps`=0 ⇒ `row_valid` never asserted; `done` at cycle 1; `spins_out`=`spin_init`.
- **Reset mid-run:** `rst_n` asserted asynchronously mid-DRAIN ⇒ all outputs 0 immediately; `start` while `busy` ignored.
